// File: rtl/bcd_sseg_scan.sv
// Multiplexed common-anode seven-segment scanner with tear-free shadow/active BCD registers.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_sseg_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);

    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   shadow_bcd_q, shadow_bcd_d;
    logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0]   active_bcd_q, active_bcd_d;
    logic [DIGITS-1:0]     active_dp_q, active_dp_d;
    logic                  wrap_q, wrap_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  frame_q, frame_d;

    logic                  tick;
    logic [3:0]            cur_digit;
    logic                  lz_blank;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        tick         = (pcnt_q == PW'(REFRESH_DIV - 1));
        wrap_d       = tick && (idx_q == IW'(DIGITS - 1));
        pcnt_d       = tick ? '0 : pcnt_q + PW'(1);
        idx_d        = idx_q;
        if (tick) begin
            idx_d = wrap_d ? '0 : idx_q + IW'(1);
        end

        shadow_bcd_d = load ? bcd   : shadow_bcd_q;
        shadow_dp_d  = load ? dp_in : shadow_dp_q;
        active_bcd_d = active_bcd_q;
        active_dp_d  = active_dp_q;
        // A load on the boundary cycle bypasses the shadow so the new frame is never stale.
        if (wrap_d) begin
            active_bcd_d = shadow_bcd_d;
            active_dp_d  = shadow_dp_d;
        end

        cur_digit = active_bcd_q[4*idx_q +: 4];
        lz_blank  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lz_blank = (idx_q != '0);
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(idx_q) && active_bcd_q[4*j +: 4] != 4'd0) begin
                lz_blank = 1'b0;
            end
        end
`endif
        seg_d   = lz_blank ? 7'b1111111 : decode(cur_digit);
        dp_d    = ~active_dp_q[idx_q];
        an_d    = ~(DIGITS'(1) << idx_q);
        frame_d = wrap_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q       <= '0;
            idx_q        <= '0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            active_bcd_q <= '0;
            active_dp_q  <= '0;
            wrap_q       <= 1'b0;
            seg_q        <= 7'b1111111;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_q      <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            active_bcd_q <= active_bcd_d;
            active_dp_q  <= active_dp_d;
            wrap_q       <= wrap_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_q      <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_bcd_sseg_scan.sv
// Self-checking bench for bcd_sseg_scan (DIGITS=4, REFRESH_DIV=4); reference model is cycle-count based.
// Define LEADING_ZERO_BLANK_EN for both bench and RTL to exercise blanking.
module tb_bcd_sseg_scan;

    localparam int D  = 4;
    localparam int RD = 4;
    localparam int FR = D * RD;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] bcd;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    always #5 clk = ~clk;

    bcd_sseg_scan #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .bcd   (bcd),
        .dp_in (dp_in),
        .seg   (seg),
        .dp    (dp),
        .an    (an),
        .frame (frame)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc;
    logic [15:0] m_shadow, m_active;
    logic [3:0]  m_sdp, m_adp;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    function automatic logic [6:0] exp_seg(input logic [15:0] val, input int dig);
        logic [15:0] sh;
        sh = val >> (4 * dig);
`ifdef LEADING_ZERO_BLANK_EN
        if (dig >= 1 && sh == 16'h0) return 7'h7F;
`endif
        return seg_tab[sh[3:0]];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        cyc      = 0;
        m_shadow = '0;
        m_active = '0;
        m_sdp    = '0;
        m_adp    = '0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_seg"},   16'(seg),   16'h7F);
        check({tag, "_dp"},    16'(dp),    16'h1);
        check({tag, "_an"},    16'(an),    16'hF);
        check({tag, "_frame"}, 16'(frame), 16'h0);
    endtask

    // One clock: outputs after the edge reflect the digit and active value of the cycle just ended.
    task automatic step(input logic ld, input logic [15:0] b, input logic [3:0] d);
        int         dig;
        logic [6:0] es;
        logic       ed;
        logic [3:0] ea;
        logic       ef;
        load  = ld;
        bcd   = b;
        dp_in = d;
        @(posedge clk);
        dig = (cyc / RD) % D;
        es  = exp_seg(m_active, dig);
        ed  = ~m_adp[dig];
        ea  = ~(4'b0001 << dig);
        ef  = (cyc % FR == 0) && (cyc > 0);
        if (ld) begin
            m_shadow = b;
            m_sdp    = d;
        end
        if (cyc % FR == FR - 1) begin
            m_active = m_shadow;
            m_adp    = m_sdp;
        end
        cyc++;
        #1;
        check("seg",   16'(seg),   16'(es));
        check("dp",    16'(dp),    16'(ed));
        check("an",    16'(an),    16'(ea));
        check("frame", 16'(frame), 16'(ef));
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic run_to(input int phase);
        while (cyc % FR != phase) step(1'b0, 16'h0, 4'h0);
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        bcd   = '0;
        dp_in = '0;
        model_reset();
        #12;
        check_reset("por");
        @(negedge clk);
        rst = 1'b0;

        // Free-running scan with nothing loaded.
        idle(16);

        // Mid-frame load held until the boundary.
        run_to(6);
        step(1'b1, 16'h1234, 4'b0100);
        run_to(0);
        idle(17);

        // Two loads in one frame: last one wins.
        run_to(2);
        step(1'b1, 16'h1111, 4'b0000);
        run_to(9);
        step(1'b1, 16'h0098, 4'b0000);
        run_to(0);
        idle(16);

        // Load on the exact boundary cycle.
        run_to(15);
        step(1'b1, 16'h5555, 4'b0001);
        idle(16);

        // Invalid codes show a dash.
        run_to(3);
        step(1'b1, 16'hFA07, 4'b1010);
        run_to(0);
        idle(16);

        // Asynchronous reset during digit 2.
        step(1'b1, 16'h9999, 4'b1111);
        run_to(0);
        run_to(9);
        #2;
        rst = 1'b1;
        #1;
        check_reset("async_rst");
        @(posedge clk);
        #1;
        check_reset("held_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(8);

        // Randomised loads, including ones landing on boundary cycles.
        for (int i = 0; i < 300; i++) begin
            step(1'(($urandom % 8) == 0), 16'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_sseg_scan.md
# bcd_sseg_scan

Multiplexed seven-segment display driver that consumes packed BCD digits from the binary-to-BCD conversion stage. It time-multiplexes DIGITS common-anode digits on one shared segment bus. A shadow/active register pair makes value updates tear-free: a new value is shown only from the start of a scan frame. It sits directly downstream of `binary_bcd` and drives the board display pins.

## Interface
- `DIGITS`, 4: number of BCD digits scanned, 2..8.
- `REFRESH_DIV`, 50000: clock cycles each digit stays lit, ≥2.

- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `load` input 1: one-cycle strobe; captures `bcd` and `dp_in` into the shadow register.
- `bcd` input 4*DIGITS: packed BCD. Digit i is `bcd[4i+3:4i]`; digit 0 is least significant.
- `dp_in` input DIGITS: decimal point request per digit, active-high.
- `seg` output 7: `{g,f,e,d,c,b,a}`, active-low, registered.
- `dp` output 1: decimal point, active-low, registered.
- `an` output DIGITS: digit enables, active-low, one-hot-low, registered.
- `frame` output 1: one-cycle pulse on the cycle the active register reloads, registered.

## Operation
- Prescaler `pcnt` counts 0..REFRESH_DIV-1 and wraps. `tick` = (`pcnt` == REFRESH_DIV-1).
- Digit index `idx` advances on `tick`, wrapping DIGITS-1 → 0. The wrap is the frame boundary.
- `load` writes `bcd`/`dp_in` into the shadow register. The last `load` before a boundary wins.
- At each frame boundary, shadow copies to active. If `load` occurs on the boundary cycle, the new `bcd`/`dp_in` go directly to both shadow and active.
- Output decode from active digit `idx`:
  - 0 → 1000000
  - 1 → 1111001
  - 2 → 0100100
  - 3 → 0110000
  - 4 → 0011001
  - 5 → 0010010
  - 6 → 0000010
  - 7 → 1111000
  - 8 → 0000000
  - 9 → 0010000
  - codes 10..15 → dash 0111111
- `an` = ~(1 << `idx`).
- `dp` = ~`dp_in_active[idx]`, never blanked.

## Timing
- Reset (async) values:
  - `pcnt`=0, `idx`=0, shadow=0, active=0.
  - `seg`=1111111, `dp`=1, `an`=all ones, `frame`=0.
- First rising edge after reset release: outputs show digit 0 of active (value 0 → `seg`=1000000, `an`=…1110).
- Output latency: `seg`/`dp`/`an` reflect `idx` and active content with one-cycle register latency. `an` and `seg` change on the same edge.
- Each digit is driven for exactly REFRESH_DIV consecutive cycles. A full frame is DIGITS*REFRESH_DIV cycles.
- `frame` is high for the one cycle in which `an` first selects digit 0 of the new frame. It does not pulse for the initial post-reset frame.
- `load` to visible change: at most one frame plus one cycle; at least one cycle, when `load` falls on the boundary cycle.
- Reset asserted mid-frame clears everything immediately, with no wait for clock. The scan restarts at digit 0.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: digit i (i ≥ 1) shows `seg`=1111111 when it and all higher active digits are 0. Invalid codes count as nonzero. Digit 0 is never blanked. `dp` is unaffected.
- Undefined: all digits are always decoded, and leading zeros display as 0.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4.
- Reset then run 16 cycles, no load → `an` cycles 1110,1101,1011,0111 with 4 cycles each. `seg`=1000000 on every digit without the macro. With the macro, `seg`=1000000 only on digit 0 and 1111111 elsewhere.
- `load` with `bcd`=16'h1234, `dp_in`=4'b0100 mid-frame → old value held until the boundary. Next frame shows digit0=0011001, digit1=0110000, digit2=0100100 with `dp`=0, digit3=1111001. `frame` pulses once.
- Two `load`s in one frame (16'h1111, then 16'h0098) → only 0098 is displayed. With the macro, digits 2 and 3 are blank, digit1=0010000, digit0=0000000.
- `load` on the exact boundary cycle with 16'h5555 → the new frame's digit 0 shows 0010010 immediately. There is no stale frame.
- `bcd`=16'hFA07 → digits 3 and 2 show 0111111 (dash), digit1=1000000, digit0=1111000.
- Assert `rst` during digit 2 after loading 16'h9999 → all outputs go to reset values asynchronously. After release, the scan restarts at `an`=1110 with `seg`=1000000.
